// File: rtl/wbdma_chain.sv
// Descriptor-chain sequencer: fetches 5-word descriptors over the main bus,
// programs the DMA controller for each one and polls its status until idle.
module wbdma_chain #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int POLL_GAP = 15
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_swb_cyc,
    input  logic          i_swb_stb,
    input  logic          i_swb_we,
    input  logic [1:0]    i_swb_addr,
    input  logic [DW-1:0] i_swb_data,
    output logic          o_swb_ack,
    output logic          o_swb_stall,
    output logic [DW-1:0] o_swb_data,
    output logic          o_fwb_cyc,
    output logic          o_fwb_stb,
    output logic          o_fwb_we,
    output logic [AW-1:0] o_fwb_addr,
    input  logic          i_fwb_ack,
    input  logic          i_fwb_stall,
    input  logic          i_fwb_err,
    input  logic [DW-1:0] i_fwb_data,
    output logic          o_dwb_cyc,
    output logic          o_dwb_stb,
    output logic          o_dwb_we,
    output logic [1:0]    o_dwb_addr,
    output logic [DW-1:0] o_dwb_data,
    input  logic          i_dwb_ack,
    input  logic          i_dwb_stall,
    input  logic [DW-1:0] i_dwb_data,
    output logic          o_interrupt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_PROG  = 3'd2;
    localparam logic [2:0] S_POLL  = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    localparam logic [3:0]    GAP        = POLL_GAP[3:0];
    localparam logic [DW-1:0] ABORT_WORD = 32'hffed_0000;

    logic [2:0]    r_state;
    logic          r_swb_ack;
    logic [DW-1:0] r_swb_data;
    logic          r_fwb_cyc, r_fwb_stb;
    logic [AW-1:0] r_fwb_addr;
    logic          r_dwb_cyc, r_dwb_stb, r_dwb_we;
    logic [1:0]    r_dwb_addr;
    logic [DW-1:0] r_dwb_data;
    logic          r_irq;
    logic          r_err;
    logic [15:0]   r_done_cnt;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_cur;
    logic [DW-1:0] r_status;
    logic          r_abort_pend;
    logic [2:0]    r_widx;
    logic [1:0]    r_pidx;
    logic [3:0]    r_gap;
    logic [DW-1:0] r_desc [0:4];

    logic          w_swb_req, w_swb_wr, w_ctl_wr;
    logic          w_busy, w_start, w_abort, w_abort_any;
    logic [DW-1:0] w_rd_data;
    logic [1:0]    w_prog_addr;
    logic [DW-1:0] w_prog_data;

    assign w_swb_req   = i_swb_cyc && i_swb_stb;
    assign w_swb_wr    = w_swb_req && i_swb_we;
    assign w_ctl_wr    = w_swb_wr && (i_swb_addr == 2'd0);
    assign w_busy      = (r_state != S_IDLE);
    assign w_start     = w_ctl_wr && i_swb_data[0] && !w_busy;
    assign w_abort     = w_ctl_wr && i_swb_data[1] && w_busy;
    assign w_abort_any = w_abort || r_abort_pend;

    always_comb begin
        w_rd_data = '0;
        case (i_swb_addr)
            2'd0:    w_rd_data = {w_busy, r_err, 14'b0, r_done_cnt};
            2'd1:    w_rd_data = DW'(r_head);
            2'd2:    w_rd_data = DW'(r_cur);
            default: w_rd_data = r_status;
        endcase
    end

    // Programming order: len, src, dst, then ctrl last so the DMA starts on a full setup.
    always_comb begin
        w_prog_addr = 2'd0;
        w_prog_data = '0;
        case (r_pidx)
            2'd0:    begin w_prog_addr = 2'd1; w_prog_data = r_desc[1]; end
            2'd1:    begin w_prog_addr = 2'd2; w_prog_data = r_desc[2]; end
            2'd2:    begin w_prog_addr = 2'd3; w_prog_data = r_desc[3]; end
            default: begin
                w_prog_addr = 2'd0;
                w_prog_data = {2'b00, r_desc[0][29:28], 12'hfed, r_desc[0][15:0]};
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (r_state == S_FETCH && i_fwb_ack && !w_abort && !i_fwb_err)
            r_desc[r_widx] <= i_fwb_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_swb_ack    <= 1'b0;
            r_swb_data   <= '0;
            r_fwb_cyc    <= 1'b0;
            r_fwb_stb    <= 1'b0;
            r_fwb_addr   <= '0;
            r_dwb_cyc    <= 1'b0;
            r_dwb_stb    <= 1'b0;
            r_dwb_we     <= 1'b0;
            r_dwb_addr   <= '0;
            r_dwb_data   <= '0;
            r_irq        <= 1'b0;
            r_err        <= 1'b0;
            r_done_cnt   <= '0;
            r_head       <= '0;
            r_cur        <= '0;
            r_status     <= '0;
            r_abort_pend <= 1'b0;
            r_widx       <= '0;
            r_pidx       <= '0;
            r_gap        <= '0;
        end else begin
            r_swb_ack <= w_swb_req;
            r_irq     <= 1'b0;
            if (w_swb_req && !i_swb_we)
                r_swb_data <= w_rd_data;
            if (w_swb_wr && i_swb_addr == 2'd1 && !w_busy)
                r_head <= i_swb_data[AW-1:0];
            if (w_abort)
                r_abort_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_abort_pend <= 1'b0;
                    if (w_start) begin
                        r_err      <= 1'b0;
                        r_done_cnt <= '0;
                        r_cur      <= r_head;
                        r_fwb_addr <= r_head;
                        r_fwb_cyc  <= 1'b1;
                        r_fwb_stb  <= 1'b1;
                        r_widx     <= '0;
                        r_state    <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (w_abort || i_fwb_err) begin
                        r_fwb_cyc    <= 1'b0;
                        r_fwb_stb    <= 1'b0;
                        r_err        <= 1'b1;
                        r_irq        <= 1'b1;
                        r_abort_pend <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        if (r_fwb_stb && !i_fwb_stall)
                            r_fwb_stb <= 1'b0;
                        if (i_fwb_ack) begin
                            if (r_widx == 3'd4) begin
                                r_fwb_cyc <= 1'b0;
                                r_fwb_stb <= 1'b0;
                                r_pidx    <= '0;
                                r_state   <= S_PROG;
                            end else begin
                                r_widx     <= r_widx + 3'd1;
                                r_fwb_addr <= r_fwb_addr + AW'(1);
                                r_fwb_stb  <= 1'b1;
                            end
                        end
                    end
                end

                S_PROG: begin
                    if (r_dwb_cyc) begin
                        if (r_dwb_stb && !i_dwb_stall)
                            r_dwb_stb <= 1'b0;
                        if (i_dwb_ack) begin
                            r_dwb_cyc <= 1'b0;
                            r_dwb_stb <= 1'b0;
                            r_dwb_we  <= 1'b0;
                            if (w_abort_any)
                                r_state <= S_ABORT;
                            else if (r_pidx == 2'd3) begin
                                r_gap   <= GAP;
                                r_state <= S_POLL;
                            end else
                                r_pidx <= r_pidx + 2'd1;
                        end
                    end else if (w_abort_any)
                        r_state <= S_ABORT;
                    else begin
                        r_dwb_cyc  <= 1'b1;
                        r_dwb_stb  <= 1'b1;
                        r_dwb_we   <= 1'b1;
                        r_dwb_addr <= w_prog_addr;
                        r_dwb_data <= w_prog_data;
                    end
                end

                S_POLL: begin
                    if (r_dwb_cyc) begin
                        if (r_dwb_stb && !i_dwb_stall)
                            r_dwb_stb <= 1'b0;
                        if (i_dwb_ack) begin
                            r_dwb_cyc <= 1'b0;
                            r_dwb_stb <= 1'b0;
                            r_status  <= i_dwb_data;
                            if (w_abort_any)
                                r_state <= S_ABORT;
                            else if (i_dwb_data[31])
                                r_gap <= GAP;
                            else if (i_dwb_data[30]) begin
                                r_err   <= 1'b1;
                                r_irq   <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_done_cnt <= r_done_cnt + 16'd1;
                                if (r_desc[4] == '0) begin
                                    r_irq   <= 1'b1;
                                    r_state <= S_IDLE;
                                end else begin
                                    r_cur      <= r_desc[4][AW-1:0];
                                    r_fwb_addr <= r_desc[4][AW-1:0];
                                    r_fwb_cyc  <= 1'b1;
                                    r_fwb_stb  <= 1'b1;
                                    r_widx     <= '0;
                                    r_state    <= S_FETCH;
                                end
                            end
                        end
                    end else if (w_abort_any)
                        r_state <= S_ABORT;
                    else if (r_gap != 4'd0)
                        r_gap <= r_gap - 4'd1;
                    else begin
                        r_dwb_cyc  <= 1'b1;
                        r_dwb_stb  <= 1'b1;
                        r_dwb_we   <= 1'b0;
                        r_dwb_addr <= 2'd0;
                    end
                end

                S_ABORT: begin
                    if (r_dwb_cyc) begin
                        if (r_dwb_stb && !i_dwb_stall)
                            r_dwb_stb <= 1'b0;
                        if (i_dwb_ack) begin
                            r_dwb_cyc    <= 1'b0;
                            r_dwb_stb    <= 1'b0;
                            r_dwb_we     <= 1'b0;
                            r_err        <= 1'b1;
                            r_irq        <= 1'b1;
                            r_abort_pend <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end else begin
                        r_dwb_cyc  <= 1'b1;
                        r_dwb_stb  <= 1'b1;
                        r_dwb_we   <= 1'b1;
                        r_dwb_addr <= 2'd0;
                        r_dwb_data <= ABORT_WORD;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_swb_ack   = r_swb_ack;
    assign o_swb_stall = 1'b0;
    assign o_swb_data  = r_swb_data;
    assign o_fwb_cyc   = r_fwb_cyc;
    assign o_fwb_stb   = r_fwb_stb;
    assign o_fwb_we    = 1'b0;
    assign o_fwb_addr  = r_fwb_addr;
    assign o_dwb_cyc   = r_dwb_cyc;
    assign o_dwb_stb   = r_dwb_stb;
    assign o_dwb_we    = r_dwb_we;
    assign o_dwb_addr  = r_dwb_addr;
    assign o_dwb_data  = r_dwb_data;
    assign o_interrupt = r_irq;

endmodule

// File: tb/tb_wbdma_chain.sv
// Bench for wbdma_chain: descriptor memory and DMA slave models plus
// table-driven chain runs and hand-written abort/reset sequences.
module tb_wbdma_chain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_cyc = 0, s_stb = 0, s_we = 0;
    logic [1:0]  s_addr = 0;
    logic [31:0] s_data = 0;
    logic        f_ack = 0, f_stall = 0, f_err = 0;
    logic [31:0] f_data = 0;
    logic        d_ack = 0, d_stall = 0;
    logic [31:0] d_data = 0;

    logic        o_swb_ack, o_swb_stall, o_fwb_cyc, o_fwb_stb, o_fwb_we;
    logic [31:0] o_swb_data, o_fwb_addr, o_dwb_data;
    logic        o_dwb_cyc, o_dwb_stb, o_dwb_we, o_interrupt;
    logic [1:0]  o_dwb_addr;

    wbdma_chain #(.AW(32), .DW(32), .POLL_GAP(15)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_swb_cyc(s_cyc), .i_swb_stb(s_stb), .i_swb_we(s_we),
        .i_swb_addr(s_addr), .i_swb_data(s_data),
        .o_swb_ack(o_swb_ack), .o_swb_stall(o_swb_stall), .o_swb_data(o_swb_data),
        .o_fwb_cyc(o_fwb_cyc), .o_fwb_stb(o_fwb_stb), .o_fwb_we(o_fwb_we),
        .o_fwb_addr(o_fwb_addr), .i_fwb_ack(f_ack), .i_fwb_stall(f_stall),
        .i_fwb_err(f_err), .i_fwb_data(f_data),
        .o_dwb_cyc(o_dwb_cyc), .o_dwb_stb(o_dwb_stb), .o_dwb_we(o_dwb_we),
        .o_dwb_addr(o_dwb_addr), .o_dwb_data(o_dwb_data),
        .i_dwb_ack(d_ack), .i_dwb_stall(d_stall), .i_dwb_data(d_data),
        .o_interrupt(o_interrupt)
    );

    always #5 clk = ~clk;

    // Model state (responder process owns the counters; the test only reads them).
    logic [31:0] mem [0:1023];
    logic [33:0] dlog [$];
    int          fcount = 0, dreads = 0, irq_cnt = 0, ccount = 0, busy_left = 0;
    logic [31:0] dma_len = 0;
    int          err_at = -1, cfg_polls = 0;
    logic [31:0] final_status = 0;

    int checks = 0, errors = 0;

    always @(negedge clk) begin
        ccount++;
        f_stall = (ccount % 3 == 0);
        f_ack = 0;
        f_err = 0;
        if (o_fwb_cyc && o_fwb_stb && !f_stall) begin
            if (fcount == err_at) f_err = 1;
            else begin
                f_ack  = 1;
                f_data = mem[o_fwb_addr[9:0]];
            end
            fcount++;
        end
        d_ack = 0;
        if (o_dwb_cyc && o_dwb_stb && !d_stall) begin
            d_ack = 1;
            if (o_dwb_we) begin
                dlog.push_back({o_dwb_addr, o_dwb_data});
                if (o_dwb_addr == 2'd1) dma_len = o_dwb_data;
                if (o_dwb_addr == 2'd0 && o_dwb_data != 32'hffed_0000)
                    busy_left = (dma_len == 0) ? 0 : cfg_polls;
            end else begin
                dreads++;
                if (busy_left > 0) begin
                    d_data = 32'h8000_0000;
                    busy_left--;
                end else d_data = final_status;
            end
        end
        if (o_interrupt) irq_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic swb_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        s_cyc = 1; s_stb = 1; s_we = 1; s_addr = a; s_data = d;
        @(negedge clk);
        s_cyc = 0; s_stb = 0; s_we = 0;
    endtask

    task automatic swb_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        s_cyc = 1; s_stb = 1; s_we = 0; s_addr = a;
        @(negedge clk);
        s_cyc = 0; s_stb = 0;
        chk("swb_ack", o_swb_ack, 1);
        d = o_swb_data;
    endtask

    task automatic wait_irq(input int budget, input int base);
        bit seen = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (irq_cnt != base) begin seen = 1; break; end
        end
        chk("irq_seen", seen, 1);
    endtask

    typedef struct {
        logic [31:0] head;
        int          polls;
        logic [31:0] fin;
        int          err_idx;
        int          exp_fetch;
        int          exp_reads;
        int          exp_writes;
        logic [31:0] exp_reg0;
        logic [31:0] exp_reg3;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] rd;
    int          fb, rb, wb, ib;
    bit          hit;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h040] = 32'h0000_0010; mem[32'h041] = 8;
        mem[32'h042] = 32'h2000;      mem[32'h043] = 32'h3000; mem[32'h044] = 0;
        mem[32'h100] = 32'hF000_ABCD; mem[32'h101] = 16;
        mem[32'h102] = 32'h1000;      mem[32'h103] = 32'h1800; mem[32'h104] = 32'h200;
        mem[32'h200] = 32'h0000_0001; mem[32'h201] = 4;
        mem[32'h202] = 32'h1100;      mem[32'h203] = 32'h1900; mem[32'h204] = 32'h300;
        mem[32'h300] = 32'h0000_0002; mem[32'h301] = 0;
        mem[32'h302] = 32'h1200;      mem[32'h303] = 32'h1A00; mem[32'h304] = 0;

        //        head      polls fin            eidx fetch reads wr  reg0           reg3
        vecs[0] = '{32'h040, 3, 32'h0,          -1,  5,    4,    4,  32'h0000_0001, 32'h0};
        vecs[1] = '{32'h100, 2, 32'h0,          -1,  15,   7,    12, 32'h0000_0003, 32'h0};
        vecs[2] = '{32'h040, 3, 32'h0,          2,   3,    0,    0,  32'h4000_0000, 32'h0};
        vecs[3] = '{32'h040, 1, 32'h4000_0000,  -1,  5,    2,    4,  32'h4000_0000, 32'h4000_0000};
        vecs[4] = '{32'h100, 2, 32'h0,          7,   8,    3,    4,  32'h4000_0001, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {o_fwb_cyc, o_fwb_stb, o_fwb_we, o_dwb_cyc, o_dwb_stb, o_dwb_we,
                        o_swb_ack, o_swb_stall, o_interrupt}, 0);
        chk("rst_data", {o_swb_data, o_fwb_addr}, 0);
        chk("rst_dwb", {o_dwb_addr, o_dwb_data}, 0);
        @(negedge clk);
        rst = 0;
        for (int r = 0; r < 4; r++) begin
            swb_read(r[1:0], rd);
            chk("rst_reg", rd, 0);
        end

        for (int i = 0; i < 5; i++) begin
            cfg_polls = vecs[i].polls;
            final_status = vecs[i].fin;
            fb = fcount; rb = dreads; wb = dlog.size(); ib = irq_cnt;
            err_at = (vecs[i].err_idx < 0) ? -1 : fb + vecs[i].err_idx;
            swb_write(2'd1, vecs[i].head);
            swb_write(2'd0, 32'h1);
            chk("start_fcyc", o_fwb_cyc, 1);
            wait_irq(3000, ib);
            repeat (5) @(negedge clk);
            chk("fetches", fcount - fb, vecs[i].exp_fetch);
            chk("polls", dreads - rb, vecs[i].exp_reads);
            chk("dwrites", dlog.size() - wb, vecs[i].exp_writes);
            chk("irq_count", irq_cnt - ib, 1);
            swb_read(2'd0, rd);
            chk("reg0", rd, vecs[i].exp_reg0);
            swb_read(2'd3, rd);
            chk("reg3", rd, vecs[i].exp_reg3);
            if (i == 0) begin
                chk("wr0", dlog[wb + 0], {2'd1, 32'd8});
                chk("wr1", dlog[wb + 1], {2'd2, 32'h2000});
                chk("wr2", dlog[wb + 2], {2'd3, 32'h3000});
                chk("wr3", dlog[wb + 3], {2'd0, 32'h0fed_0010});
            end
            if (i == 1) begin
                chk("ctrl_mask", dlog[wb + 3], {2'd0, 32'h3fed_abcd});
                chk("ctrl_d2", dlog[wb + 7], {2'd0, 32'h0fed_0001});
                chk("zero_len", dlog[wb + 8], {2'd1, 32'd0});
            end
        end

        // Busy-time writes ignored, then abort while a poll read is held by stall.
        err_at = -1; cfg_polls = 1000; final_status = 0;
        fb = fcount; rb = dreads; wb = dlog.size(); ib = irq_cnt;
        swb_write(2'd1, 32'h040);
        swb_write(2'd0, 32'h1);
        swb_write(2'd1, 32'h100);
        swb_read(2'd1, rd);
        chk("head_busy", rd, 32'h040);
        swb_write(2'd0, 32'h1);
        hit = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (dreads - rb >= 1) begin hit = 1; break; end
        end
        chk("first_poll", hit, 1);
        @(posedge clk); #1 d_stall = 1;
        hit = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (o_dwb_cyc && o_dwb_stb && !o_dwb_we) begin hit = 1; break; end
        end
        chk("poll_held", hit, 1);
        swb_write(2'd0, 32'h2);
        chk("abort_hold", {o_dwb_cyc, o_dwb_we}, 2'b10);
        chk("abort_nowr", dlog.size() - wb, 4);
        @(posedge clk); #1 d_stall = 0;
        wait_irq(500, ib);
        repeat (3) @(negedge clk);
        chk("abort_wr", dlog[dlog.size() - 1], {2'd0, 32'hffed_0000});
        chk("abort_wcnt", dlog.size() - wb, 5);
        chk("busy_start", fcount - fb, 5);
        chk("abort_irq", irq_cnt - ib, 1);
        swb_read(2'd0, rd);
        chk("abort_reg0", rd, 32'h4000_0000);

        // Abort during descriptor fetch.
        fb = fcount; wb = dlog.size(); ib = irq_cnt;
        swb_write(2'd1, 32'h100);
        swb_write(2'd0, 32'h1);
        swb_write(2'd0, 32'h2);
        wait_irq(100, ib);
        repeat (3) @(negedge clk);
        chk("fabort_part", (fcount - fb) < 5, 1);
        chk("fabort_nowr", dlog.size() - wb, 0);
        chk("fabort_irq", irq_cnt - ib, 1);
        swb_read(2'd0, rd);
        chk("fabort_reg0", rd, 32'h4000_0000);

        // Reset while a DMA programming write is stalled.
        ib = irq_cnt; cfg_polls = 2;
        @(posedge clk); #1 d_stall = 1;
        swb_write(2'd1, 32'h040);
        swb_write(2'd0, 32'h1);
        hit = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_dwb_cyc) begin hit = 1; break; end
        end
        chk("prog_stalled", hit, 1);
        rst = 1;
        @(posedge clk); #1;
        chk("mid_rst_ctl", {o_fwb_cyc, o_fwb_stb, o_dwb_cyc, o_dwb_stb, o_dwb_we,
                            o_swb_ack, o_interrupt}, 0);
        chk("mid_rst_dwb", {o_dwb_addr, o_dwb_data, o_fwb_addr}, 0);
        @(negedge clk);
        rst = 0;
        d_stall = 0;
        swb_read(2'd0, rd);
        chk("mid_rst_reg0", rd, 0);
        swb_read(2'd1, rd);
        chk("mid_rst_head", rd, 0);
        chk("mid_rst_irq", irq_cnt - ib, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
